// File: rtl/irl_tb_policer_pkg.sv
// Shared types for the two-rate three-color token-bucket policer: colors, profile/state records,
// default widths and the saturating lazy-refill helper.
package irl_package;

    localparam int IRL_TOK_NBITS  = 24;
    localparam int IRL_RATE_NBITS = 16;
    localparam int IRL_TS_NBITS   = 16;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2
    } irl_color_e;

    typedef struct packed {
        logic [IRL_RATE_NBITS-1:0] cir;
        logic [IRL_RATE_NBITS-1:0] eir;
        logic [IRL_TOK_NBITS-1:0]  cbs;
        logic [IRL_TOK_NBITS-1:0]  ebs;
    } irl_tb_profile_t;

    typedef struct packed {
        logic [IRL_TOK_NBITS-1:0] ctok;
        logic [IRL_TOK_NBITS-1:0] etok;
        logic [IRL_TS_NBITS-1:0]  last_ts;
    } irl_tb_state_t;

    // tok + rate*elapsed, with the product saturated to the bucket width and the sum capped at burst.
    function automatic logic [IRL_TOK_NBITS-1:0] refill(
        input logic [IRL_TOK_NBITS-1:0]  tok,
        input logic [IRL_RATE_NBITS-1:0] rate,
        input logic [IRL_TS_NBITS-1:0]   elapsed,
        input logic [IRL_TOK_NBITS-1:0]  burst
    );
        logic [IRL_RATE_NBITS+IRL_TS_NBITS-1:0] add_full;
        logic [IRL_TOK_NBITS-1:0]               add;
        logic [IRL_TOK_NBITS:0]                 sum;
        add_full = {{IRL_TS_NBITS{1'b0}}, rate} * {{IRL_RATE_NBITS{1'b0}}, elapsed};
        if (|add_full[IRL_RATE_NBITS+IRL_TS_NBITS-1:IRL_TOK_NBITS])
            add = '1;
        else
            add = add_full[IRL_TOK_NBITS-1:0];
        sum = {1'b0, tok} + {1'b0, add};
        if (sum > {1'b0, burst})
            return burst;
        return sum[IRL_TOK_NBITS-1:0];
    endfunction

endpackage

// File: rtl/irl_tb_policer_calc.sv
// Combinational refill, color decision and debit for one flow; lives in pipeline stage P2.
module irl_tb_calc
    import irl_package::*;
#(
    parameter int LEN_NBITS = 14
) (
    input  irl_tb_profile_t           prof,
    input  irl_tb_state_t             state,
    input  logic [IRL_TS_NBITS-1:0]   now,
    input  logic [LEN_NBITS-1:0]      len,
    input  irl_color_e                pre_color,
    output irl_color_e                color,
    output irl_tb_state_t             next_state
);

    logic [IRL_TS_NBITS-1:0]  elapsed;
    logic [IRL_TOK_NBITS-1:0] ctok_r;
    logic [IRL_TOK_NBITS-1:0] etok_r;
    logic [IRL_TOK_NBITS-1:0] len_ext;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        elapsed = now - state.last_ts;
        ctok_r  = refill(state.ctok, prof.cir, elapsed, prof.cbs);
        etok_r  = refill(state.etok, prof.eir, elapsed, prof.ebs);
        len_ext = {{(IRL_TOK_NBITS-LEN_NBITS){1'b0}}, len};

        color              = RED;
        next_state.ctok    = ctok_r;
        next_state.etok    = etok_r;
        next_state.last_ts = now;

        if (pre_color == GREEN && len_ext <= ctok_r) begin
            color           = GREEN;
            next_state.ctok = ctok_r - len_ext;
        end else if ((pre_color == GREEN || pre_color == YELLOW) && len_ext <= etok_r) begin
            color           = YELLOW;
            next_state.etok = etok_r - len_ext;
        end
    end

endmodule

// File: rtl/irl_tb_policer.sv
// Per-flow trTCM policer, 2-cycle pipeline with P2->P1 state forwarding.
// Define IRL_COLOR_AWARE_EN to honour req_color; otherwise every packet is treated as pre-colored green.
module irl_tb_policer
    import irl_package::*;
#(
    parameter int N_FLOWS    = 64,
    parameter int LEN_NBITS  = 14,
    parameter int TOK_NBITS  = IRL_TOK_NBITS,
    parameter int RATE_NBITS = IRL_RATE_NBITS,
    parameter int TS_NBITS   = IRL_TS_NBITS,
    localparam int FLOW_NBITS = $clog2(N_FLOWS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ts_tick,
    input  logic                  cfg_wr,
    input  logic [FLOW_NBITS-1:0] cfg_flow,
    input  logic [RATE_NBITS-1:0] cfg_cir,
    input  logic [RATE_NBITS-1:0] cfg_eir,
    input  logic [TOK_NBITS-1:0]  cfg_cbs,
    input  logic [TOK_NBITS-1:0]  cfg_ebs,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FLOW_NBITS-1:0] req_flow,
    input  logic [LEN_NBITS-1:0]  req_len,
    input  logic [1:0]            req_color,
    output logic                  res_valid,
    output logic [FLOW_NBITS-1:0] res_flow,
    output logic [1:0]            res_color,
    output logic                  res_drop
);

    irl_tb_profile_t prof_mem  [N_FLOWS];
    irl_tb_state_t   state_mem [N_FLOWS];
    logic [N_FLOWS-1:0] cfg_valid_q;

    logic [TS_NBITS-1:0] ts_q;
    logic                rdy_q;

    logic                  p1_valid;
    logic [FLOW_NBITS-1:0] p1_flow;
    logic [LEN_NBITS-1:0]  p1_len;
    irl_color_e            p1_color;

    logic                  p2_valid;
    logic [FLOW_NBITS-1:0] p2_flow;
    logic [LEN_NBITS-1:0]  p2_len;
    irl_color_e            p2_color;
    logic                  p2_kill;
    logic                  p2_cfgd;
    irl_tb_profile_t       p2_prof;
    irl_tb_state_t         p2_state;

    irl_color_e    calc_color;
    irl_color_e    p2_verdict;
    irl_tb_state_t calc_next;
    irl_tb_state_t p1_state;
    irl_color_e    in_color;
    logic          accept;
    logic          cfg_hit_p1;
    logic          cfg_hit_p2;
    logic          p2_wb;
    logic          fwd;

`ifdef IRL_COLOR_AWARE_EN
    assign in_color = irl_color_e'(req_color);
`else
    logic unused_req_color;
    assign unused_req_color = ^req_color;
    assign in_color         = GREEN;
`endif

    assign req_ready = rdy_q & ~cfg_wr;
    assign accept    = req_valid & req_ready;

    // A cfg write to a flow with a request in flight wins: that request keeps its verdict but loses its writeback.
    assign cfg_hit_p1 = cfg_wr && p1_valid && (cfg_flow == p1_flow);
    assign cfg_hit_p2 = cfg_wr && p2_valid && (cfg_flow == p2_flow);
    assign p2_wb      = p2_valid && p2_cfgd && !p2_kill && !cfg_hit_p2;
    assign fwd        = p2_wb && (p2_flow == p1_flow);
    assign p1_state   = fwd ? calc_next : state_mem[p1_flow];
    assign p2_verdict = p2_cfgd ? calc_color : RED;

    irl_tb_calc #(.LEN_NBITS(LEN_NBITS)) u_calc (
        .prof       (p2_prof),
        .state      (p2_state),
        .now        (ts_q),
        .len        (p2_len),
        .pre_color  (p2_color),
        .color      (calc_color),
        .next_state (calc_next)
    );

    // NOTE: the profile/token arrays are plain RAM with no reset; cfg_valid_q gates every use of them.
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            prof_mem[cfg_flow]  <= '{cir: cfg_cir, eir: cfg_eir, cbs: cfg_cbs, ebs: cfg_ebs};
            state_mem[cfg_flow] <= '{ctok: cfg_cbs, etok: cfg_ebs, last_ts: ts_q};
        end
        if (p2_wb)
            state_mem[p2_flow] <= calc_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_valid_q <= '0;
            ts_q        <= '0;
            rdy_q       <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (ts_tick)
                ts_q <= ts_q + {{(TS_NBITS-1){1'b0}}, 1'b1};
            if (cfg_wr)
                cfg_valid_q[cfg_flow] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid  <= 1'b0;
            p1_flow   <= '0;
            p1_len    <= '0;
            p1_color  <= GREEN;
            p2_valid  <= 1'b0;
            p2_flow   <= '0;
            p2_len    <= '0;
            p2_color  <= GREEN;
            p2_kill   <= 1'b0;
            p2_cfgd   <= 1'b0;
            p2_prof   <= '0;
            p2_state  <= '0;
            res_valid <= 1'b0;
            res_flow  <= '0;
            res_color <= '0;
            res_drop  <= 1'b0;
        end else begin
            p1_valid <= accept;
            p1_flow  <= req_flow;
            p1_len   <= req_len;
            p1_color <= in_color;

            p2_valid <= p1_valid;
            p2_flow  <= p1_flow;
            p2_len   <= p1_len;
            p2_color <= p1_color;
            p2_kill  <= cfg_hit_p1;
            p2_cfgd  <= cfg_valid_q[p1_flow];
            p2_prof  <= prof_mem[p1_flow];
            p2_state <= p1_state;

            res_valid <= p2_valid;
            res_flow  <= p2_flow;
            res_color <= p2_verdict;
            res_drop  <= (p2_verdict == RED);
        end
    end

endmodule

// File: tb/tb_irl_tb_policer.sv
// Scoreboard bench for irl_tb_policer: directed requests push expected verdicts, a monitor pops and compares.
module tb_irl_tb_policer;
    import irl_package::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ts_tick = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [5:0]  cfg_flow = '0;
    logic [15:0] cfg_cir = '0;
    logic [15:0] cfg_eir = '0;
    logic [23:0] cfg_cbs = '0;
    logic [23:0] cfg_ebs = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_flow = '0;
    logic [13:0] req_len = '0;
    logic [1:0]  req_color = '0;
    logic        res_valid;
    logic [5:0]  res_flow;
    logic [1:0]  res_color;
    logic        res_drop;

    irl_tb_policer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ts_tick   (ts_tick),
        .cfg_wr    (cfg_wr),
        .cfg_flow  (cfg_flow),
        .cfg_cir   (cfg_cir),
        .cfg_eir   (cfg_eir),
        .cfg_cbs   (cfg_cbs),
        .cfg_ebs   (cfg_ebs),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_flow  (req_flow),
        .req_len   (req_len),
        .req_color (req_color),
        .res_valid (res_valid),
        .res_flow  (res_flow),
        .res_color (res_color),
        .res_drop  (res_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] flow;
        logic [1:0] color;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    // Monitor: every verdict must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (res_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_result: got flow %0d color %0d, expected no result (t=%0t)",
                             res_flow, res_color, $time);
                end else begin
                    automatic exp_t e = sb.pop_front();
                    check("res_flow", {26'd0, res_flow}, {26'd0, e.flow});
                    check("res_color", {30'd0, res_color}, {30'd0, e.color});
                    check("res_drop", {31'd0, res_drop}, {31'd0, (e.color == 2'd2)});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion, expected $finish before 2 ms");
        $fatal(1, "simulation time limit");
    end

    task automatic send(input logic [5:0] f, input logic [13:0] l, input logic [1:0] c,
                        input logic [1:0] expc, input bit track = 1'b1);
        req_valid = 1'b1;
        req_flow  = f;
        req_len   = l;
        req_color = c;
        if (track) sb.push_back('{f, expc});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic cfg(input logic [5:0] f, input logic [15:0] cir, input logic [15:0] eir,
                       input logic [23:0] cbs, input logic [23:0] ebs);
        cfg_wr   = 1'b1;
        cfg_flow = f;
        cfg_cir  = cir;
        cfg_eir  = eir;
        cfg_cbs  = cbs;
        cfg_ebs  = ebs;
        @(negedge clk);
        cfg_wr   = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
        check(name, sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    localparam logic [1:0] G = 2'd0, Y = 2'd1, R = 2'd2;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_res_valid", {31'd0, res_valid}, 0);
        check("reset_res_color", {30'd0, res_color}, 0);
        check("reset_res_drop", {31'd0, res_drop}, 0);
        check("reset_res_flow", {26'd0, res_flow}, 0);
        check("reset_req_ready", {31'd0, req_ready}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", {31'd0, req_ready}, 1);
        @(negedge clk);

        // Overdraw, then probe the residual ctok=400 / etok=50.
        cfg(6'd3, 16'd0, 16'd0, 24'd1000, 24'd500);
        send(6'd3, 14'd600, G, G);
        send(6'd3, 14'd600, G, R);
        send(6'd3, 14'd450, G, Y);
        send(6'd3, 14'd401, G, R);
        send(6'd3, 14'd400, G, G);
        send(6'd3, 14'd51, G, R);
        send(6'd3, 14'd50, G, Y);
        drain("drain_overdraw");

        // Refill: 100 ticks at cir=4 restores exactly 400 tokens.
        cfg(6'd5, 16'd4, 16'd0, 24'd1000, 24'd0);
        send(6'd5, 14'd1000, G, G);
        repeat (4) @(negedge clk);
        ts_tick = 1'b1;
        repeat (100) @(negedge clk);
        ts_tick = 1'b0;
        send(6'd5, 14'd400, G, G);
        send(6'd5, 14'd1, G, R);
        drain("drain_refill");

        // Back-to-back same-flow requests exercise forwarding.
        cfg(6'd9, 16'd0, 16'd0, 24'd1000, 24'd0);
        for (int i = 0; i < 5; i++) send(6'd9, 14'd300, G, (i < 3) ? G : R);
        drain("drain_forward");

        // Unconfigured flow, then configured.
        send(6'd7, 14'd1, G, R);
        drain("drain_unconf");
        cfg(6'd7, 16'd0, 16'd0, 24'd800, 24'd0);
        send(6'd7, 14'd800, G, G);
        drain("drain_cfg7");

        // cfg write lands while a request to the same flow is in P1: verdict stays, writeback is dropped.
        cfg(6'd13, 16'd0, 16'd0, 24'd1000, 24'd0);
        send(6'd13, 14'd600, G, G);
        cfg(6'd13, 16'd0, 16'd0, 24'd1000, 24'd0);
        send(6'd13, 14'd1000, G, G);
        send(6'd13, 14'd1, G, R);
        drain("drain_collision");

        // Pre-color handling.
        cfg(6'd11, 16'd0, 16'd0, 24'd1000, 24'd500);
`ifdef IRL_COLOR_AWARE_EN
        send(6'd11, 14'd100, Y, Y);
        send(6'd11, 14'd100, R, R);
        send(6'd11, 14'd1000, G, G);
        send(6'd11, 14'd400, G, Y);
        send(6'd11, 14'd1, G, R);
`else
        send(6'd11, 14'd100, Y, G);
        send(6'd11, 14'd100, R, G);
        send(6'd11, 14'd800, G, G);
        send(6'd11, 14'd500, G, Y);
        send(6'd11, 14'd1, G, R);
`endif
        drain("drain_color");

        // Reset with two requests in flight: both vanish and all flows become unconfigured.
        send(6'd3, 14'd1, G, G, 1'b0);
        send(6'd9, 14'd1, G, G, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset_res_valid", {31'd0, res_valid}, 0);
        check("midreset_req_ready", {31'd0, req_ready}, 0);
        repeat (3) @(negedge clk);
        check("midreset_res_valid_hold", {31'd0, res_valid}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_midreset", {31'd0, req_ready}, 1);
        @(negedge clk);
        send(6'd3, 14'd1, G, R);
        send(6'd9, 14'd1, G, R);
        drain("drain_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/irl_tb_policer.md
# irl_tb_policer

Parametrised two-rate, three-color token-bucket policer for the ingress rate-limit path. It sits between classification and the lookup handoff as the next-generation rate-limit engine. It holds per-flow CIR/EIR profiles and bucket state in internal arrays, refills lazily from a shared timestamp, and returns a green/yellow/red verdict per packet. The pipeline runs at full throughput and forwards state between back-to-back requests to the same flow.

## Interface
- N_FLOWS, 64: number of policed flows; FLOW_NBITS = $clog2(N_FLOWS)
- LEN_NBITS, 14: packet length width (bytes)
- TOK_NBITS, 24: bucket and burst-size width
- RATE_NBITS, 16: tokens added per timestamp tick
- TS_NBITS, 16: timestamp counter width
- clk  in  1  core clock
- `RESET_SIG (rst_n)  in  1  asynchronous, active-low reset
- ts_tick  in  1  advances the internal timestamp by 1 (clk_div-style pulse)
- cfg_wr  in  1  profile write strobe
- cfg_flow  in  FLOW_NBITS  flow being configured
- cfg_cir, cfg_eir  in  RATE_NBITS  committed / excess refill rates
- cfg_cbs, cfg_ebs  in  TOK_NBITS  committed / excess burst sizes
- req_valid  in  1  policing request
- req_ready  out  1  request accepted when valid && ready
- req_flow  in  FLOW_NBITS  flow id
- req_len  in  LEN_NBITS  packet length
- req_color  in  2  pre-color: 0 green, 1 yellow, 2 red
- res_valid  out  1  verdict strobe
- res_flow  out  FLOW_NBITS  echoed flow id
- res_color  out  2  verdict color, same encoding
- res_drop  out  1  verdict is red

## Operation
- Per-flow state: cfg_valid bit, ctok, etok, last_ts. The profile array and token array are not reset. cfg_valid resets to 0.
- cfg_wr loads the profile and sets ctok=cbs, etok=ebs, last_ts=now, cfg_valid=1.
- Refill on access:
  - elapsed = (now - last_ts) mod 2^TS_NBITS.
  - add = rate*elapsed, RATE_NBITS+TS_NBITS bits wide, saturated to TOK_NBITS.
  - tok = min(tok + add, burst).
  - Idle gaps longer than 2^TS_NBITS ticks alias. Software sizes TS_NBITS so that the wrap time is at least the burst fill time.
- Decision, with len zero-extended to TOK_NBITS:
  - Green: len <= ctok and green is allowed. ctok -= len.
  - Otherwise yellow: len <= etok and yellow is allowed. etok -= len.
  - Otherwise red. No debit.
  - last_ts = now in every case.
- An unconfigured flow always yields red with no writeback.
- A cfg_wr collision with an in-flight request for the same flow is resolved in favour of the cfg write. The in-flight verdict is still issued, using the old state, but its writeback is suppressed.
- req_ready = 0 in any cycle where cfg_wr = 1, and 0 during reset. Otherwise it is 1.

## Timing
- Pipeline stages:
  - Edge E0 accepts the request into P1.
  - P1 reads the arrays.
  - P2 refills, decides and writes back at E2. res_* is registered at E2.
  - Latency is 2 cycles; throughput is 1 request/cycle.
- Forwarding: if the P1 flow equals the P2 flow, P1 takes P2's post-decision ctok/etok/last_ts instead of the array values. Consecutive same-flow requests must match the serialized result.
- Timestamp: the timestamp increments at the edge where ts_tick = 1. now is sampled in P2.
- Reset values: res_valid=0, res_color=0, res_drop=0, res_flow=0, req_ready=0, timestamp=0, all cfg_valid=0.
- Reset asserted mid-operation:
  - In-flight requests are discarded with no res_valid.
  - Every flow becomes unconfigured.
  - req_ready returns to 1 one cycle after deassertion.

## Configuration
- IRL_COLOR_AWARE_EN defined: req_color is honoured.
  - Pre-color yellow can only yield yellow or red.
  - Pre-color red yields red with no debit.
- IRL_COLOR_AWARE_EN undefined: color-blind operation. req_color is ignored and treated as green.

## Structure
- Shared package irl_package holds:
  - irl_color_e (GREEN=0, YELLOW=1, RED=2)
  - an irl_tb_profile_t struct (cir, eir, cbs, ebs)
  - an irl_tb_state_t struct (ctok, etok, last_ts)
- Sub-module irl_tb_calc: the combinational refill/saturate/compare/debit for one flow. It is instantiated once in P2.

## Test plan
- Overdraw: flow 3 configured with cbs=1000, ebs=500, rates=0. Requests len 600, 600, 450 give green, red, yellow. End state is ctok=400, etok=50.
- Refill: cir=4, cbs=1000, ebs=0. Drain with len 1000 (green), wait 100 ts_ticks, then len 400 gives green and the next len 1 gives red.
- Forwarding: cbs=1000, ebs=0. Five back-to-back len-300 requests to one flow give green, green, green, red, red.
- Unconfigured flow 7: a request gives res_color=2 and res_drop=1. A subsequent cfg of flow 7 then accepts len ≤ cbs as green.
- Color-aware build: full buckets with pre-color yellow gives yellow and etok is debited. Color-blind build gives green. In the aware build, pre-color red gives red and no tokens change.
- Reset with 2 requests in flight: no res_valid follows. req_ready is 1 one cycle after release. The prior flows now return red.
